// File: rtl/ibex_instr_realigner_pkg.sv
// Shared constants and helpers for the IF-stage instruction realigner.
package ibex_instr_realigner_pkg;
  localparam int unsigned XLEN = 32;

  // Same rule the compressed decoder uses to recognise a 16-bit instruction
  function automatic logic is_compressed(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction
endpackage

// File: rtl/ibex_fetch_word_fifo.sv
// DEPTH-entry fetch word FIFO exposing the head and head+1 entries combinationally.
module ibex_fetch_word_fifo
  import ibex_instr_realigner_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned PW = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            push_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            werr_i,
  input  logic            pop_i,
  output logic [CW-1:0]   count_o,
  output logic [XLEN-1:0] w0_rdata_o,
  output logic            w0_err_o,
  output logic [XLEN-1:0] w1_rdata_o,
  output logic            w1_err_o
);
  logic [XLEN-1:0] data_q [DEPTH];
  logic            err_q  [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_nxt;
  logic [CW-1:0]   count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rd_nxt = ptr_inc(rd_ptr_q);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = rd_nxt;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        err_q[i]  <= 1'b0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push_i && !clear_i) begin
        data_q[wr_ptr_q] <= wdata_i;
        err_q[wr_ptr_q]  <= werr_i;
      end
    end
  end

  assign count_o    = count_q;
  assign w0_rdata_o = data_q[rd_ptr_q];
  assign w0_err_o   = err_q[rd_ptr_q];
  assign w1_rdata_o = data_q[rd_nxt];
  assign w1_err_o   = err_q[rd_nxt];
endmodule

// File: rtl/ibex_instr_realigner.sv
// Turns word-aligned fetch responses into one realigned (compressed or 32-bit) instruction per handshake.
module ibex_instr_realigner
  import ibex_instr_realigner_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic [XLEN-1:0] branch_addr_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] in_rdata_i,
  input  logic            in_err_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_rdata_o,
  output logic [XLEN-1:0] out_addr_o,
  output logic            out_err_o
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [CW-1:0]   count;
  logic [XLEN-1:0] w0_rdata, w1_rdata, pc_q, pc_d;
  logic            w0_err, w1_err, push, pop, fire, comp;
  logic [15:0]     hw;
  logic            unused_bits;

  ibex_fetch_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .push_i     (push),
    .wdata_i    (in_rdata_i),
    .werr_i     (in_err_i),
    .pop_i      (pop),
    .count_o    (count),
    .w0_rdata_o (w0_rdata),
    .w0_err_o   (w0_err),
    .w1_rdata_o (w1_rdata),
    .w1_err_o   (w1_err)
  );

  assign in_ready_o = count < CW'(DEPTH);
  assign push       = in_valid_i && in_ready_o && !clear_i;

  assign hw   = pc_q[1] ? w0_rdata[31:16] : w0_rdata[15:0];
  assign comp = is_compressed(hw);

  always_comb begin
    out_valid_o = 1'b0;
    out_rdata_o = '0;
    out_err_o   = 1'b0;
    if (count != '0) begin
      if (w0_err) begin
        out_valid_o = 1'b1;
        out_err_o   = 1'b1;
      end else if (comp) begin
        out_valid_o = 1'b1;
        out_rdata_o = {16'h0, hw};
      end else if (!pc_q[1]) begin
        out_valid_o = 1'b1;
        out_rdata_o = w0_rdata;
      end else if (count >= CW'(2)) begin
        // Straddle: upper half of w0 is the low parcel, w1 supplies the high parcel
        out_valid_o = 1'b1;
        out_rdata_o = {w1_rdata[15:0], hw};
        out_err_o   = w1_err;
      end
    end
  end

  assign fire = out_valid_o && out_ready_i && !clear_i;
  // Only an aligned compressed instruction leaves part of w0 for the next one
  assign pop  = fire && (pc_q[1] || !comp || w0_err);

  always_comb begin
    pc_d = pc_q;
    if (clear_i) begin
      pc_d = {branch_addr_i[XLEN-1:1], 1'b0};
    end else if (fire) begin
      pc_d = pc_q + ((w0_err ? !pc_q[1] : !comp) ? XLEN'(4) : XLEN'(2));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pc_q <= '0;
    else         pc_q <= pc_d;
  end

  assign out_addr_o  = pc_q;
  assign unused_bits = branch_addr_i[0] ^ (^w1_rdata[31:16]);
endmodule

// File: tb/tb_ibex_instr_realigner.sv
// Directed bench for the realigner with an expectation queue and a separate output monitor.
module tb_ibex_instr_realigner;
  logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic [31:0] br_addr = '0, in_rdata = '0;
  logic        in_valid = 1'b0, in_err = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, out_err;
  logic [31:0] out_rdata, out_addr;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int total = 0, passed = 0;

  ibex_instr_realigner #(.DEPTH(3)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_i       (clear),
    .branch_addr_i (br_addr),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_rdata_i    (in_rdata),
    .in_err_i      (in_err),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_rdata_o   (out_rdata),
    .out_addr_o    (out_addr),
    .out_err_o     (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every accepted instruction must match the head of the expectation queue
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !clear) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_addr", out_addr, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_addr", out_addr, e.addr);
        chk("out_err", {31'h0, out_err}, {31'h0, e.err});
        if (!e.err) chk("out_rdata", out_rdata, e.rdata);
      end
    end
  end

  task automatic expect_out(input logic [31:0] d, input logic [31:0] a, input logic e);
    exp_t x;
    x.rdata = d; x.addr = a; x.err = e;
    sb.push_back(x);
  endtask

  task automatic do_clear(input logic [31:0] a);
    clear = 1'b1; br_addr = a;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic push(input logic [31:0] d, input logic e);
    int n = 0;
    in_valid = 1'b1; in_rdata = d; in_err = e;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) chk("push_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_left", sb.size(), 32'h0);
  endtask

  initial begin
    logic [31:0] held_d, held_a;
    #2;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_out_addr", out_addr, 32'h0);
    chk("rst_out_rdata", out_rdata, 32'h0);
    chk("rst_out_err", {31'h0, out_err}, 32'h0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // Aligned stream
    do_clear(32'h100);
    expect_out(32'h00B50533, 32'h100, 1'b0);
    expect_out(32'h00004585, 32'h104, 1'b0);
    expect_out(32'h00004501, 32'h106, 1'b0);
    push(32'h00B50533, 1'b0);
    push(32'h45014585, 1'b0);
    drain();

    // Straddle across two fetch words
    do_clear(32'h200);
    expect_out(32'h00004585, 32'h200, 1'b0);
    push(32'h05334585, 1'b0);
    drain();
    repeat (3) @(posedge clk); #1;
    chk("straddle_withheld", {31'h0, out_valid}, 32'h0);
    expect_out(32'h00B50533, 32'h202, 1'b0);
    expect_out(32'h0000ABCD, 32'h206, 1'b0);
    push(32'hABCD00B5, 1'b0);
    drain();

    // Unaligned branch target
    do_clear(32'h302);
    expect_out(32'h00004505, 32'h302, 1'b0);
    push(32'h4505FFFF, 1'b0);
    drain();
    @(posedge clk); #1;
    chk("unal_empty_valid", {31'h0, out_valid}, 32'h0);
    chk("unal_empty_ready", {31'h0, in_ready}, 32'h1);

    // Faulting w0 reported without waiting for w1
    do_clear(32'h402);
    expect_out(32'h0, 32'h402, 1'b1);
    push(32'h12345678, 1'b1);
    drain();

    // Straddle whose second word faults
    do_clear(32'h502);
    push(32'h05334585, 1'b0);
    chk("str_err_wait", {31'h0, out_valid}, 32'h0);
    expect_out(32'h0, 32'h502, 1'b1);
    expect_out(32'h0, 32'h506, 1'b1);
    push(32'h000000B5, 1'b1);
    drain();

    // Backpressure until full, stable outputs, then drain
    out_ready = 1'b0;
    do_clear(32'h600);
    expect_out(32'h00000013, 32'h600, 1'b0);
    expect_out(32'h00100093, 32'h604, 1'b0);
    expect_out(32'h00200113, 32'h608, 1'b0);
    expect_out(32'h00300193, 32'h60C, 1'b0);
    push(32'h00000013, 1'b0);
    held_d = out_rdata; held_a = out_addr;
    push(32'h00100093, 1'b0);
    push(32'h00200113, 1'b0);
    in_valid = 1'b1; in_rdata = 32'h00300193; in_err = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("full_in_ready", {31'h0, in_ready}, 32'h0);
    chk("bp_stable_rdata", out_rdata, 32'h00000013);
    chk("bp_stable_vs_first", out_rdata, held_d);
    chk("bp_stable_addr", out_addr, held_a);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Clear with a push in the same cycle
    out_ready = 1'b0;
    do_clear(32'h700);
    push(32'h00000013, 1'b0);
    push(32'h00100093, 1'b0);
    chk("pre_clear_valid", {31'h0, out_valid}, 32'h1);
    clear = 1'b1; br_addr = 32'h800;
    in_valid = 1'b1; in_rdata = 32'hDEADBEEF; in_err = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_out_valid", {31'h0, out_valid}, 32'h0);
    chk("clr_in_ready", {31'h0, in_ready}, 32'h1);
    chk("clr_addr", out_addr, 32'h800);
    out_ready = 1'b1;
    expect_out(32'h00000013, 32'h800, 1'b0);
    push(32'h00000013, 1'b0);
    drain();
    repeat (2) @(posedge clk); #1;
    chk("clr_drop_valid", {31'h0, out_valid}, 32'h0);

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    do_clear(32'h904);
    push(32'h00000013, 1'b0);
    chk("prereset_valid", {31'h0, out_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'h0, out_valid}, 32'h0);
    chk("arst_addr", out_addr, 32'h0);
    chk("arst_in_ready", {31'h0, in_ready}, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
